mem_resp_pipe: RTL and testbench

- Memory-side responder for the cache fill path, serving the requests issued by the cache-fill FSM: enable/wr/addr/data_in in, data_out/data_valid back.
- Reads are pipelined with fixed LATENCY. One new read is accepted every cycle, so an 8-word block fill returns 8 back-to-back valid words.
- Writes from the write-through path commit in one cycle.
- Sits between the cache top level and the word-addressed backing store, which this block contains.

---
 rtl/mem_resp_pipe_pkg.sv | 8 +
 rtl/mem_resp_pipe_if.sv | 26 ++
 rtl/mem_resp_pipe_resp_delay_pipe.sv | 39 +++
 rtl/mem_resp_pipe.sv | 79 +++++++
 tb/tb_mem_resp_pipe.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mem_resp_pipe_pkg.sv
// Constants shared between the cache-fill FSM and the memory-side responder.
package mem_resp_pipe_pkg;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int MEM_LATENCY = 4;
    localparam int BLOCK_WORDS = 8;
    localparam int CNT_W       = 4;
endpackage

// File: rtl/mem_resp_pipe_if.sv
// Request/response bundle between the cache fill path and mem_resp_pipe.
interface mem_resp_pipe_if #(
    parameter int DATA_W = mem_resp_pipe_pkg::DATA_W,
    parameter int ADDR_W = mem_resp_pipe_pkg::ADDR_W
);
    import mem_resp_pipe_pkg::*;

    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic [CNT_W-1:0]  outstanding;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, busy, outstanding
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, busy, outstanding
    );
endinterface

// File: rtl/mem_resp_pipe_resp_delay_pipe.sv
// LATENCY-deep shift register of {valid, data}; only the valid bits are reset.
module resp_delay_pipe #(
    parameter int DATA_W  = mem_resp_pipe_pkg::DATA_W,
    parameter int LATENCY = mem_resp_pipe_pkg::MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy
);
    logic [LATENCY-1:0] r_vld_p;
    logic [DATA_W-1:0]  r_data_p [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= i_vld;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld_p[s] <= r_vld_p[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_data_p[0] <= i_data;
        for (int s = 1; s < LATENCY; s++) begin
            r_data_p[s] <= r_data_p[s-1];
        end
    end

    // Output stage: data is forced to zero whenever its valid bit is low.
    assign o_vld  = r_vld_p[LATENCY-1];
    assign o_data = r_vld_p[LATENCY-1] ? r_data_p[LATENCY-1] : '0;
    assign o_busy = |r_vld_p;
endmodule

// File: rtl/mem_resp_pipe.sv
// Word-addressed backing store with single-cycle writes and fixed-latency pipelined reads.
module mem_resp_pipe #(
    parameter int DATA_W     = mem_resp_pipe_pkg::DATA_W,
    parameter int ADDR_W     = mem_resp_pipe_pkg::ADDR_W,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = mem_resp_pipe_pkg::MEM_LATENCY
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_resp_pipe_if.slave  bus
);
    import mem_resp_pipe_pkg::*;

    localparam int WORDS = 1 << DEPTH_LOG2;

    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        case ({inc, dec})
            2'b10:   return cur + 1'b1;
            2'b01:   return cur - 1'b1;
            default: return cur;
        endcase
    endfunction

    logic [DATA_W-1:0]     r_mem [WORDS];
    logic [CNT_W-1:0]      r_outstanding;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_rd;
    logic                  w_wr;
    logic [DATA_W-1:0]     w_rd_data;
    logic                  w_vld_out;
    logic [DATA_W-1:0]     w_data_out;
    logic                  w_busy;
    logic                  w_unused_addr;

    // Byte address: bit 0 and bits above the word index alias onto the same word.
    assign w_idx         = bus.addr[DEPTH_LOG2:1];
    assign w_unused_addr = ^{bus.addr[ADDR_W-1:DEPTH_LOG2+1], bus.addr[0]};
    assign w_rd          = bus.enable & ~bus.wr;
    assign w_wr          = bus.enable &  bus.wr;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= bus.data_in;
        end
    end

    // Issue stage: data is sampled now, so later writes cannot affect it.
    assign w_rd_data = r_mem[w_idx];

    resp_delay_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (w_rd),
        .i_data (w_rd_data),
        .o_vld  (w_vld_out),
        .o_data (w_data_out),
        .o_busy (w_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= next_count(r_outstanding, w_rd, w_vld_out);
        end
    end

    assign bus.data_out    = w_data_out;
    assign bus.data_valid  = w_vld_out;
    assign bus.busy        = w_busy;
    assign bus.outstanding = r_outstanding;
endmodule

// File: tb/tb_mem_resp_pipe.sv
// Directed bench for mem_resp_pipe with hand-computed cycle-by-cycle expectations.
module tb_mem_resp_pipe;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   peak;

    mem_resp_pipe_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_resp_pipe #(
        .DATA_W     (16),
        .ADDR_W     (16),
        .DEPTH_LOG2 (10),
        .LATENCY    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.enable  = en;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic dv, input logic [15:0] dout,
                             input logic [3:0] outs, input logic bsy);
        check_val({tag, ".dv"},   {31'd0, bus.data_valid}, {31'd0, dv});
        check_val({tag, ".dout"}, {16'd0, bus.data_out},   {16'd0, dout});
        check_val({tag, ".outs"}, {28'd0, bus.outstanding}, {28'd0, outs});
        check_val({tag, ".busy"}, {31'd0, bus.busy},       {31'd0, bsy});
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        drive(1'b1, 1'b1, a, d);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0);

        // Reset then idle
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_out("rst", 1'b0, 16'h0, 4'd0, 1'b0);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_out("idle", 1'b0, 16'h0, 4'd0, 1'b0);
            next_cycle();
        end

        // Single write then read
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
            else if (c == 1) drive(1'b1, 1'b0, 16'h0010, 16'h0);
            else             drive(1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            check_out("single", c == 5, (c == 5) ? 16'hBEEF : 16'h0,
                      (c >= 2 && c <= 5) ? 4'd1 : 4'd0, c >= 2 && c <= 5);
            next_cycle();
        end

        // Block fill of 8 words
        for (int i = 0; i < 8; i++) write_word(16'h0040 + 16'(2 * i), 16'h1000 + 16'(i));
        peak = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive(1'b1, 1'b0, 16'h0040 + 16'(2 * c), 16'h0);
            else       drive(1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            if (int'(bus.outstanding) > peak) peak = int'(bus.outstanding);
            check_out("fill", c >= 4 && c <= 11,
                      (c >= 4 && c <= 11) ? 16'h1000 + 16'(c - 4) : 16'h0,
                      (c <= 4) ? 4'(c) : (c <= 8) ? 4'd4 : (c <= 12) ? 4'(12 - c) : 4'd0,
                      c >= 1 && c <= 11);
            next_cycle();
        end
        check_val("fill.peak", 32'(peak), 32'd4);

        // Write after read issue must not disturb in-flight data
        write_word(16'h0020, 16'h1111);
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      drive(1'b1, 1'b0, 16'h0020, 16'h0);
            else if (c == 1) drive(1'b1, 1'b1, 16'h0020, 16'h2222);
            else if (c == 2) drive(1'b1, 1'b0, 16'h0020, 16'h0);
            else             drive(1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            check_val("war.dv", {31'd0, bus.data_valid}, {31'd0, (c == 4 || c == 6)});
            check_val("war.dout", {16'd0, bus.data_out},
                      (c == 4) ? 32'h1111 : (c == 6) ? 32'h2222 : 32'h0);
            next_cycle();
        end

        // Aliasing: high address bits and bit 0 ignored
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      drive(1'b1, 1'b1, 16'h0802, 16'hA5A5);
            else if (c == 1) drive(1'b1, 1'b0, 16'h0002, 16'h0);
            else if (c == 2) drive(1'b1, 1'b0, 16'h0003, 16'h0);
            else             drive(1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            check_val("alias.dv", {31'd0, bus.data_valid}, {31'd0, (c == 5 || c == 6)});
            check_val("alias.dout", {16'd0, bus.data_out},
                      (c == 5 || c == 6) ? 32'hA5A5 : 32'h0);
            next_cycle();
        end

        // Reset mid-fill drops in-flight reads
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 16'h0040 + 16'(2 * c), 16'h0);
            @(negedge clk);
            check_out("prerst", 1'b0, 16'h0, 4'(c), c >= 1);
            next_cycle();
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check_val("prerst.outs3", {28'd0, bus.outstanding}, 32'd3);
        rst_n = 1'b0;
        #1;
        check_out("midrst", 1'b0, 16'h0, 4'd0, 1'b0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_out("postrst", 1'b0, 16'h0, 4'd0, 1'b0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
